// File: rtl/hub_slot_ctl.sv
// Hub slot controller: divides clk_cog into hub windows, rotates (or skips idle)
// the selected cog each window, and flags cogs that wait too long for the hub.

module hub_slot_wdog #(
  parameter int WD_LIMIT = 16
) (
  input  logic clk_cog,
  input  logic nres,
  input  logic req,
  input  logic ack,
  input  logic ena,
  input  logic clr,
  output logic starve
);
  localparam logic [7:0] LIM_M1 = 8'(WD_LIMIT - 1);

  logic [7:0] wcnt_q, wcnt_d;
  logic       starve_q, starve_d;
  logic       hit_clr, hit_set;

  always_comb begin
    hit_clr  = !req || ack;
    // set fires only on the increment that lands exactly on the limit
    hit_set  = !hit_clr && ena && (wcnt_q == LIM_M1);
    wcnt_d   = wcnt_q;
    if (hit_clr)                      wcnt_d = '0;
    else if (ena && wcnt_q != 8'hFF)  wcnt_d = wcnt_q + 8'd1;
    starve_d = hit_set || (starve_q && !clr);
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      wcnt_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
endmodule

module hub_slot_ctl #(
  parameter int ENA_DIV  = 2,
  parameter int WD_LIMIT = 16
) (
  input  logic       clk_cog,
  input  logic       nres,
  input  logic [7:0] cog_ena,
  input  logic       skip,
  input  logic [7:0] req,
  input  logic [7:0] bus_ack,
  input  logic [7:0] starve_clr,
  output logic       ena_bus,
  output logic [7:0] bus_sel,
  output logic [2:0] slot_num,
  output logic [7:0] starve
);
  localparam logic [2:0] DIV_MAX = 3'(ENA_DIV - 1);

  logic [2:0] div_cnt_q, div_cnt_d;
  logic       ena_bus_q, ena_bus_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] bus_sel_q, bus_sel_d;
  logic [7:0] mask;
  logic [2:0] idx;
  logic       found;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_MAX) ? 3'd0 : div_cnt_q + 3'd1;
    ena_bus_d = (div_cnt_q == DIV_MAX);

    mask   = cog_ena | req;
    slot_d = slot_q;
    idx    = slot_q;
    found  = 1'b0;
    if (ena_bus_q) begin
      slot_d = slot_q + 3'd1;
      // offset 8 wraps to the current slot, so it is checked last
      if (skip) begin
        for (int i = 1; i <= 8; i++) begin
          idx = slot_q + i[2:0];
          if (!found && mask[idx]) begin
            slot_d = idx;
            found  = 1'b1;
          end
        end
      end
    end
    bus_sel_d = 8'b1 << slot_d;
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      div_cnt_q <= '0;
      ena_bus_q <= 1'b0;
      slot_q    <= '0;
      bus_sel_q <= 8'b0000_0001;
    end else begin
      div_cnt_q <= div_cnt_d;
      ena_bus_q <= ena_bus_d;
      slot_q    <= slot_d;
      bus_sel_q <= bus_sel_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_lane
      hub_slot_wdog #(.WD_LIMIT(WD_LIMIT)) u_wdog (
        .clk_cog (clk_cog),
        .nres    (nres),
        .req     (req[g]),
        .ack     (bus_ack[g]),
        .ena     (ena_bus_q),
        .clr     (starve_clr[g]),
        .starve  (starve[g])
      );
    end
  endgenerate

  assign ena_bus  = ena_bus_q;
  assign bus_sel  = bus_sel_q;
  assign slot_num = slot_q;
endmodule

// File: tb/tb_hub_slot_ctl.sv
// Directed bench for hub_slot_ctl: window cadence, rotation/skip selection,
// starvation watchdog and asynchronous reset behaviour.

module tb_hub_slot_ctl;
  logic       clk = 1'b0;
  logic       nres;
  logic [7:0] cog_ena, req, bus_ack, starve_clr;
  logic       skip;
  logic       ena_bus, ena_bus1;
  logic [7:0] bus_sel, bus_sel1, starve, starve1;
  logic [2:0] slot_num, slot_num1;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hub_slot_ctl #(.ENA_DIV(2), .WD_LIMIT(3)) u_dut (
    .clk_cog(clk), .nres(nres), .cog_ena(cog_ena), .skip(skip), .req(req),
    .bus_ack(bus_ack), .starve_clr(starve_clr), .ena_bus(ena_bus),
    .bus_sel(bus_sel), .slot_num(slot_num), .starve(starve)
  );

  hub_slot_ctl #(.ENA_DIV(1), .WD_LIMIT(3)) u_dut1 (
    .clk_cog(clk), .nres(nres), .cog_ena(cog_ena), .skip(skip), .req(req),
    .bus_ack(bus_ack), .starve_clr(starve_clr), .ena_bus(ena_bus1),
    .bus_sel(bus_sel1), .slot_num(slot_num1), .starve(starve1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance to the next cycle with ena_bus=1, bounded
  task automatic wait_win();
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ena_bus === 1'b1) return;
    end
    tests++;
    fails++;
    $error("FAIL wait_win: got no ena_bus expected window within 20 cycles");
  endtask

  task automatic expect_slots(input int n, input string tag);
    int s;
    for (int k = 0; k < n; k++) begin
      wait_win();
      s = exp_q.pop_front();
      check(tag, 32'(slot_num), 32'(s));
      check({tag, "_sel"}, 32'(bus_sel), 32'(8'b1 << s));
    end
  endtask

  initial begin
    nres = 1'b0; cog_ena = '0; req = '0; bus_ack = '0; starve_clr = '0; skip = 1'b0;
    #12;
    check("rst_ena", 32'(ena_bus), 0);
    check("rst_sel", 32'(bus_sel), 32'h01);
    check("rst_slot", 32'(slot_num), 0);
    check("rst_starve", 32'(starve), 0);

    // cadence, 9 windows of plain rotation, and ENA_DIV=1 instance
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    @(negedge clk); nres = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("div2_ena", 32'(ena_bus), 32'(k % 2 == 0));
      if (k % 2 == 0) begin
        int s;
        s = exp_q.pop_front();
        check("rot_slot", 32'(slot_num), 32'(s));
        check("rot_sel", 32'(bus_sel), 32'(8'b1 << s));
      end
      if (k <= 10) begin
        check("div1_ena", 32'(ena_bus1), 1);
        check("div1_sel", 32'(bus_sel1), 32'(8'b1 << ((k - 1) % 8)));
      end
    end

    // skip idle slots: only cogs 0 and 4 running
    skip = 1'b1; cog_ena = 8'h11;
    exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(0);
    expect_slots(4, "skip_40");
    cog_ena = 8'h00;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    expect_slots(3, "skip_empty");

    // request from cog 6 pulls the slot in ahead of the wrap to 0
    cog_ena = 8'h11;
    exp_q.push_back(4);
    expect_slots(1, "skip_to4");
    req = 8'h40;
    exp_q.push_back(6); exp_q.push_back(0);
    expect_slots(2, "skip_req6");
    req = 8'h00;
    check("no_starve6", 32'(starve), 0);

    // watchdog on cog 2 with WD_LIMIT=3
    skip = 1'b0; cog_ena = 8'h00; req = 8'h04;
    wait_win();
    check("wd_edge1", 32'(starve), 0);
    wait_win();
    check("wd_edge2", 32'(starve), 0);
    starve_clr = 8'h04;
    tick();
    check("wd_set_over_clr", 32'(starve), 32'h04);
    starve_clr = 8'h00;
    tick();
    check("wd_sticky", 32'(starve), 32'h04);
    starve_clr = 8'h04;
    tick();
    check("wd_clear", 32'(starve), 0);
    starve_clr = 8'h00;
    wait_win();
    bus_ack = 8'h04;
    tick();
    bus_ack = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      wait_win();
      tick();
      check("wd_after_ack", 32'(starve), (i == 3) ? 32'h04 : 32'h00);
    end

    // all cogs starve, park on slot 5, then reset during the window
    req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      wait_win();
      tick();
    end
    check("starve_all", 32'(starve), 32'hFF);
    req = 8'h00; skip = 1'b1; cog_ena = 8'h20;
    wait_win();
    wait_win();
    check("pre_rst_slot", 32'(slot_num), 5);
    check("pre_rst_ena", 32'(ena_bus), 1);
    #2 nres = 1'b0;
    #1;
    check("arst_ena", 32'(ena_bus), 0);
    check("arst_sel", 32'(bus_sel), 32'h01);
    check("arst_slot", 32'(slot_num), 0);
    check("arst_starve", 32'(starve), 0);
    tick();
    tick();
    check("hold_rst_ena", 32'(ena_bus), 0);
    check("hold_rst_sel", 32'(bus_sel), 32'h01);
    @(negedge clk); nres = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("post_rst_ena", 32'(ena_bus), 32'(k == 2 || k == 4));
      if (k == 2) check("post_rst_slot", 32'(slot_num), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hub_slot_ctl.md
HUB_SLOT_CTL -- requirements
Module: hub_slot_ctl

Interface
REQ-001 SHALL have parameter ENA_DIV, default 2: clk_cog cycles per hub window; legal range 1..8.
REQ-002 SHALL have parameter WD_LIMIT, default 16: window count at which a waiting cog is flagged starved; legal range 1..255.
REQ-003 SHALL have port clk_cog, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port nres, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cog_ena, input, 8 bits: running-cog mask from the hub.
REQ-006 SHALL have port skip, input, 1 bit: 1 = skip idle slots, 0 = fixed rotation.
REQ-007 SHALL have port req, input, 8 bits: per-cog hub request pending (bus_e of each cog).
REQ-008 SHALL have port bus_ack, input, 8 bits: per-cog acknowledge from the hub.
REQ-009 SHALL have port starve_clr, input, 8 bits: per-cog clear pulse for the starvation flags.
REQ-010 SHALL have port ena_bus, output, 1 bit: hub window strobe.
REQ-011 SHALL have port bus_sel, output, 8 bits: one-hot selected cog.
REQ-012 SHALL have port slot_num, output, 3 bits: binary index of bus_sel.
REQ-013 SHALL have port starve, output, 8 bits: sticky per-cog starvation flags.

Function
REQ-014 SHALL drive all outputs from registers; no combinational input-to-output path.
REQ-015 SHALL count clk_cog cycles in a divider div_cnt that wraps at ENA_DIV-1.
REQ-016 SHALL register ena_bus high for exactly one cycle when div_cnt wraps, producing one pulse every ENA_DIV cycles.
REQ-017 SHALL, for ENA_DIV=1, hold ena_bus at 1 from the first edge after reset release.
REQ-018 SHALL place the first ena_bus pulse in cycle ENA_DIV after reset release.
REQ-019 SHALL keep bus_sel and slot_num stable throughout a cycle in which ena_bus=1.
REQ-020 SHALL advance bus_sel and slot_num only on an edge where ena_bus=1.
REQ-021 SHALL, when skip=0, rotate bus_sel left by one, with bit 7 wrapping to bit 0.
REQ-022 SHALL, when skip=1, form mask = cog_ena | req, sampled at that same edge.
REQ-023 SHALL, when skip=1, select the first set bit of mask scanning from slot_num+1 upward cyclically, the current slot being checked last.
REQ-024 SHALL, when skip=1 and mask = 0, rotate by one exactly as with skip=0.
REQ-025 SHALL keep bus_sel one-hot at all times, and slot_num SHALL always equal encode(bus_sel).
REQ-026 SHALL keep an 8-bit saturating wait counter wcnt[n] per cog.
REQ-027 SHALL clear wcnt[n] on any edge where req[n]=0 or bus_ack[n]=1; clear has priority over increment.
REQ-028 SHALL otherwise increment wcnt[n] by one on each edge where ena_bus=1, saturating at 255.
REQ-029 SHALL set starve[n] on the edge where wcnt[n] would reach WD_LIMIT.
REQ-030 SHALL hold starve[n] until an edge where starve_clr[n]=1 and the set condition is false; set wins over a simultaneous clear.
REQ-031 SHALL leave wcnt[n] unaffected by starve_clr[n].
REQ-032 SHALL allow cog_ena and req changes at any time, with effect at the next ena_bus edge only.

Reset
REQ-033 SHALL, while nres=0, asynchronously force div_cnt=0, ena_bus=0, bus_sel=8'b00000001, slot_num=0, wcnt[*]=0, starve=0.
REQ-034 SHALL abandon any partial window on reset assertion; no ena_bus pulse is emitted during or at the release of reset.
REQ-035 SHALL begin counting from the first rising edge after nres deasserts.

Verification
REQ-036 SHALL be checked: ENA_DIV=2, skip=0, release reset -> ena_bus high on cycles 2,4,6...; bus_sel reads 01,02,04..80,01 across 9 windows.
REQ-037 SHALL be checked: ENA_DIV=1 -> ena_bus constant 1; bus_sel rotates every cycle.
REQ-038 SHALL be checked: skip=1, cog_ena=8'b00010001, req=0, slot 0 -> slot sequence 4,0,4,0; with cog_ena=0, req=0 -> plain rotation.
REQ-039 SHALL be checked: skip=1, slot 4, cog_ena=8'b00010001, req[6]=1 -> next slot 6, then 0.
REQ-040 SHALL be checked: WD_LIMIT=3, req[2] held, no ack -> starve[2] set on the 3rd ena_bus edge; starve_clr[2] on that same edge leaves it set; a later starve_clr[2] clears it; bus_ack[2] resets wcnt[2] to 0.
REQ-041 SHALL be checked: nres pulsed low mid-window with slot 5 and starve=8'hFF -> outputs immediately at reset values; first window ENA_DIV cycles after release, at slot 0.
